mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one N-input mux tree between N requesters. It drives the tree's select bus and a one-hot grant vector so exactly one requester's data reaches the shared output at a time. It enforces a bounded tenure per owner so no single requester can monopolise the path. It sits directly upstream of the mux tree's select inputs, with the requesters' handshake on its other side.

## Interface
Parameters:
- N, 4, number of requesters / mux inputs; power of two, at least 2.
- HOLD_MAX, 8, maximum consecutive cycles an owner keeps the grant while others are waiting; at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request; level-sensitive, held while the requester wants the path.
- gnt  output  N  one-hot grant, or all zero when idle; registered.
- sel  output  $clog2(N)  mux tree select, equal to the index of the set gnt bit; registered.
- busy  output  1  high while any grant is active; equals the OR of gnt.

## Operation
- State machine in package type arb_state_t with two states: IDLE and GRANT.
- Internal registers:
  - ptr ($clog2(N) bits): round-robin start index.
  - owner: current owner index.
  - cnt ($clog2(HOLD_MAX) bits, minimum 1): tenure count.
- Winner selection: the first index i with req[i]=1, scanning ptr, ptr+1, … modulo N (wrap-around). It is computed combinationally from req and the registered ptr.
- IDLE:
  - gnt=0, busy=0, sel holds its last value.
  - If any req bit is set, go to GRANT next cycle with owner=winner, gnt=onehot(winner), sel=winner, cnt=0, ptr=winner+1 mod N.
- GRANT, evaluated each cycle in priority order:
  1. req[owner]=0 (release): if another req bit is set, grant the winner next cycle directly, with no idle gap; otherwise go to IDLE with gnt=0.
  2. cnt==HOLD_MAX-1 and some other req bit is set (preempt): grant the winner next cycle. The current owner is excluded because ptr is already owner+1.
  3. Otherwise (hold): keep the grant; cnt increments and saturates at HOLD_MAX-1.
- Every new grant reloads cnt=0 and sets ptr=new owner+1 mod N.
- A re-request by the previous owner in the same cycle as its release is treated as a fresh request subject to rotation.
- req bits for non-owners are never sampled except through winner selection. Glitches on req are tolerated at cycle granularity only.

## Timing
- Reset values: gnt=0, sel=0, busy=0, state=IDLE, ptr=0, owner=0, cnt=0.
- Asserting rst clears all outputs immediately, without waiting for a clock edge. After rst falls, the first grant goes to the lowest-index requester.
- Request-to-grant latency: 1 cycle from the edge that samples req in IDLE.
- Release-to-regrant: 1 cycle, and gnt moves directly between owners. sel and gnt always change on the same edge, so sel never points at an input whose gnt is low.
- An owner keeps the grant for at most HOLD_MAX consecutive cycles while any other request is pending. With no contention, tenure is unlimited.
- HOLD_MAX=1 with all requests held rotates the grant every cycle.
- Simultaneous release and expiry is handled as release.
- Reset asserted mid-grant: the owner loses the grant instantly and ptr returns to 0.

## Structure
- Shared package mux_arb_pkg contains:
  - arb_state_t enum (IDLE, GRANT).
  - Function onehot(idx, N).
  - Localparam helper for the select width, $clog2(N).
- One combinational sub-module, rr_pick, with inputs req[N] and ptr and outputs found and idx (the rotating-priority winner). The top level holds the FSM, ptr, cnt and output registers.

## Test plan
All scenarios use N=4, HOLD_MAX=4 unless noted.
- Reset: with rst=1 and random req, gnt=0000, sel=0, busy=0 with no clock required. After release with req=1010, the next edge gives gnt=0010, sel=1.
- Single requester: req=0100 from cycle 0 gives gnt=0100, sel=2, busy=1 from cycle 1. Dropping req at cycle 20 gives gnt=0000 at cycle 21, and sel stays 2.
- Full contention: req=1111 held gives grant sequence 0,1,2,3,0, each held exactly 4 cycles with no idle gaps.
- Early release handoff: owner 1 drops req while req[3]=1 gives gnt 0010→1000 on the next edge, with cnt restarting so 3 holds for up to 4 cycles.
- Wrap fairness: after a grant to 3, with req=1001 and 3 releasing, the next grant goes to 0 (ptr wrapped to 0). With HOLD_MAX=1 and req=1111, the grant rotates every cycle.
- Async reset mid-grant: pulse rst between edges while gnt=0100, and gnt=0000 and busy=0 immediately. With req=0110 afterwards, the first grant goes to 1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux-tree arbiter.
// Imported by the picker and the top-level FSM.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // onehot() returns a fixed-width vector; callers size-cast it down to N.
  localparam int MAX_N = 64;

  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    if (idx < n)
      return MAX_N'(1) << idx;
    else
      return '0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping modulo N.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [selWidth(N)-1:0] ptr,
  output logic                   found,
  output logic [selWidth(N)-1:0] idx
);

  localparam int SW = selWidth(N);

  logic [SW-1:0] w_cand;

  // Scan from the far end back toward ptr so the closest match wins.
  always_comb begin
    found  = |req;
    idx    = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = ptr + SW'(k);
      if (req[w_cand])
        idx = w_cand;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared N-input mux tree's select and grant,
// with a bounded tenure per owner while other requesters are waiting.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  output logic [N-1:0]           gnt,
  output logic [selWidth(N)-1:0] sel,
  output logic                   busy
);

  localparam int SW = selWidth(N);
  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  arb_state_t    r_state;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_owner;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_gnt;
  logic [SW-1:0] r_sel;
  logic          r_busy;

  logic          w_found;
  logic [SW-1:0] w_idx;
  logic [N-1:0]  w_ownerOh;
  logic [N-1:0]  w_newOh;
  logic          w_ownerReq;
  logic          w_othersReq;
  logic          w_atMax;
  logic          w_doGrant;
  logic          w_toIdle;
  logic          w_incCnt;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_ownerOh   = N'(onehot(32'(r_owner), N));
  assign w_newOh     = N'(onehot(32'(w_idx), N));
  assign w_ownerReq  = |(req & w_ownerOh);
  assign w_othersReq = |(req & ~w_ownerOh);
  assign w_atMax     = (r_cnt == CW'(HOLD_MAX - 1));

  // Release beats expiry; ptr already sits past the owner, so a preempting
  // winner is always someone else.
  always_comb begin
    w_doGrant = 1'b0;
    w_toIdle  = 1'b0;
    w_incCnt  = 1'b0;
    case (r_state)
      IDLE: w_doGrant = w_found;
      GRANT: begin
        if (!w_ownerReq) begin
          w_doGrant = w_found;
          w_toIdle  = !w_found;
        end else if (w_atMax && w_othersReq) begin
          w_doGrant = 1'b1;
        end else begin
          w_incCnt = !w_atMax;
        end
      end
      default: w_toIdle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
    end else if (w_doGrant) begin
      r_state <= GRANT;
      r_owner <= w_idx;
      r_sel   <= w_idx;
      r_gnt   <= w_newOh;
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_ptr   <= w_idx + SW'(1);
    end else if (w_toIdle) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else if (w_incCnt) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: vector table plus scoreboard queue, with
// hand-written sequences for contention, async reset and HOLD_MAX=1 rotation.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] reqB = 4'b0000;
  logic [3:0] gnt, gntB;
  logic [1:0] sel, selB;
  logic       busy, busyB;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    int         reps;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    string      name;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(4), .HOLD_MAX(4)) dutA (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  mux_rr_arbiter #(.N(4), .HOLD_MAX(1)) dutB (
    .clk  (clk),
    .rst  (rst),
    .req  (reqB),
    .gnt  (gntB),
    .sel  (selB),
    .busy (busyB)
  );

  task automatic compare(input string name, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb);
    nChecks++;
    if (g === eg && s === es && b === eb)
      nPass++;
    else
      $display("[TB] FAIL %s: got gnt=%b sel=%0d busy=%b, expected gnt=%b sel=%0d busy=%b",
               name, g, s, b, eg, es, eb);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] eg,
                               input logic [1:0] es, input logic eb,
                               input string name, input bit toB);
    exp_t e;
    @(negedge clk);
    if (toB) reqB = r;
    else     req  = r;
    e.gnt  = eg;
    e.sel  = es;
    e.busy = eb;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input bit fromB);
    exp_t e;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      nChecks++;
      $display("[TB] FAIL scoreboard underflow: got queue size 0, expected at least 1");
    end else begin
      e = expQ.pop_front();
      if (fromB) compare(e.name, gntB, selB, busyB, e.gnt, e.sel, e.busy);
      else       compare(e.name, gnt, sel, busy, e.gnt, e.sel, e.busy);
    end
  endtask

  initial begin
    int o;
    exp_t e;

    vecs[0]  = '{4'b1010,  1, 4'b0010, 2'd1, 1'b1, "first grant after reset"};
    vecs[1]  = '{4'b0000,  1, 4'b0000, 2'd1, 1'b0, "release to idle"};
    vecs[2]  = '{4'b0100, 20, 4'b0100, 2'd2, 1'b1, "single requester hold"};
    vecs[3]  = '{4'b0000,  1, 4'b0000, 2'd2, 1'b0, "single requester drop"};
    vecs[4]  = '{4'b0000,  1, 4'b0000, 2'd2, 1'b0, "idle keeps sel"};
    vecs[5]  = '{4'b0010,  1, 4'b0010, 2'd1, 1'b1, "grant to 1 from ptr 3"};
    vecs[6]  = '{4'b1010,  2, 4'b0010, 2'd1, 1'b1, "owner 1 holds"};
    vecs[7]  = '{4'b1000,  1, 4'b1000, 2'd3, 1'b1, "early release handoff"};
    vecs[8]  = '{4'b1010,  3, 4'b1000, 2'd3, 1'b1, "owner 3 fresh tenure"};
    vecs[9]  = '{4'b1010,  1, 4'b0010, 2'd1, 1'b1, "preempt 3 to 1"};
    vecs[10] = '{4'b1000,  1, 4'b1000, 2'd3, 1'b1, "release 1 to 3"};
    vecs[11] = '{4'b1001,  1, 4'b1000, 2'd3, 1'b1, "owner 3 holds"};
    vecs[12] = '{4'b0011,  1, 4'b0001, 2'd0, 1'b1, "wrap to 0"};

    req = 4'($urandom);
    #1 rst = 1'b1;
    #1;
    compare("async reset no clock", gnt, sel, busy, 4'b0000, 2'd0, 1'b0);
    compare("async reset no clock B", gntB, selB, busyB, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req = 4'($urandom);
      @(posedge clk);
      #1;
      compare("reset held", gnt, sel, busy, 4'b0000, 2'd0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;

    for (int v = 0; v < 13; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        applyStimulus(vecs[v].req, vecs[v].gnt, vecs[v].sel, vecs[v].busy, vecs[v].name, 1'b0);
        checkOutput(1'b0);
      end
    end

    // Owner 0 has one cycle of tenure already; each owner then gets four.
    for (int k = 1; k <= 19; k++) begin
      o = (k / 4) % 4;
      applyStimulus(4'b1111, 4'b0001 << o, 2'(o), 1'b1, "full contention", 1'b0);
      checkOutput(1'b0);
    end

    applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b1, "handoff to 2", 1'b0);
    checkOutput(1'b0);
    #2 rst = 1'b1;
    #1;
    compare("async reset mid-grant", gnt, sel, busy, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0110;
    e.gnt  = 4'b0010;
    e.sel  = 2'd1;
    e.busy = 1'b1;
    e.name = "lowest index after reset";
    expQ.push_back(e);
    checkOutput(1'b0);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 4'b0001 << (k % 4), 2'(k % 4), 1'b1, "hold1 rotation", 1'b1);
      checkOutput(1'b1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
